mestre_barramento: RTL and testbench

MESTRE_BARRAMENTO -- requirements
Module: mestre_barramento

---
 rtl/mestre_barramento.sv | 123 ++++++++++++
 tb/tb_mestre_barramento.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mestre_barramento.sv
// Bus master for a shared tri-state data bus: one-word writes and reads with a
// programmable turnaround delay before the read sample.
module mestre_barramento #(
   parameter int Tamanho_Da_Palavra = 16,
   parameter int Ciclos_Espera      = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          req,
   input  logic                          wr,
   input  logic [Tamanho_Da_Palavra-1:0] dado_in,
   inout  wire  [Tamanho_Da_Palavra-1:0] Data,
   output logic                          io,
   output logic                          carga,
   output logic                          pronto,
   output logic [Tamanho_Da_Palavra-1:0] dado_out,
   output logic                          valido
);

   typedef enum logic [2:0] {
      OCIOSO,
      ESC_DIRIGE,
      ESC_CARGA,
      ESC_SOLTA,
      LEI_VIRA,
      LEI_AMOSTRA,
      LEI_RETORNO
   } estado_t;

   localparam logic [3:0] ULTIMA_ESPERA = 4'(Ciclos_Espera - 1);

   estado_t                         r_estado;
   logic [3:0]                      r_contador;
   logic                            r_io;
   logic                            r_carga;
   logic                            r_pronto;
   logic                            r_valido;
   logic                            r_dirige;
   logic [Tamanho_Da_Palavra-1:0]   r_palavra;
   logic [Tamanho_Da_Palavra-1:0]   r_dado_out;

   // Write word is pure data: captured on the accepting edge, never reset.
   always_ff @(posedge clock) begin
      if (r_estado == OCIOSO && req)
         r_palavra <= dado_in;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado   <= OCIOSO;
         r_contador <= '0;
         r_io       <= 1'b1;
         r_carga    <= 1'b0;
         r_pronto   <= 1'b1;
         r_valido   <= 1'b0;
         r_dirige   <= 1'b0;
         r_dado_out <= '0;
      end else begin
         r_carga  <= 1'b0;
         r_valido <= 1'b0;
         case (r_estado)
            OCIOSO: begin
               if (req) begin
                  r_pronto <= 1'b0;
                  if (wr) begin
                     r_estado <= ESC_DIRIGE;
                     r_dirige <= 1'b1;
                  end else begin
                     r_estado <= LEI_VIRA;
                     r_io     <= 1'b0;
                  end
               end
            end
            ESC_DIRIGE: begin
               r_estado <= ESC_CARGA;
               r_carga  <= 1'b1;
            end
            ESC_CARGA: begin
               r_estado <= ESC_SOLTA;
               r_dirige <= 1'b0;
            end
            ESC_SOLTA: begin
               r_estado <= OCIOSO;
               r_pronto <= 1'b1;
            end
            LEI_VIRA: begin
               if (r_contador == ULTIMA_ESPERA) begin
                  r_contador <= '0;
                  r_estado   <= LEI_AMOSTRA;
               end else begin
                  r_contador <= r_contador + 4'd1;
               end
            end
            LEI_AMOSTRA: begin
               // Raw bus value, undriven bits included, is what the caller sees.
               r_dado_out <= Data;
               r_estado   <= LEI_RETORNO;
               r_io       <= 1'b1;
               r_valido   <= 1'b1;
            end
            LEI_RETORNO: begin
               r_estado <= OCIOSO;
               r_pronto <= 1'b1;
            end
            default: begin
               r_estado   <= OCIOSO;
               r_contador <= '0;
               r_io       <= 1'b1;
               r_pronto   <= 1'b1;
               r_dirige   <= 1'b0;
            end
         endcase
      end
   end

   assign Data     = r_dirige ? r_palavra : {Tamanho_Da_Palavra{1'bz}};
   assign io       = r_io;
   assign carga    = r_carga;
   assign pronto   = r_pronto;
   assign valido   = r_valido;
   assign dado_out = r_dado_out;

endmodule

// File: tb/tb_mestre_barramento.sv
// Bench for mestre_barramento: cycle-sequence model plus directed transactions
// on a one-cycle-turnaround master and a three-cycle-turnaround master.
module tb_mestre_barramento;

   localparam int W  = 16;
   localparam int CE = 1;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         req   = 1'b0;
   logic         wr    = 1'b0;
   logic [W-1:0] dado_in = '0;
   wire  [W-1:0] Data;
   wire  [W-1:0] Data3;
   logic         io, carga, pronto, valido;
   logic         io3, carga3, pronto3, valido3;
   logic [W-1:0] dado_out, dado_out3;

   logic         per_en  = 1'b0;
   logic [W-1:0] per_val = '0;
   logic [W-1:0] per_mem = '0;
   logic [W-1:0] ZZ      = {W{1'bz}};

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   // Peripheral: drives only while the master says io=0, loads on carga.
   assign Data  = (per_en && !io)  ? per_val : {W{1'bz}};
   assign Data3 = (per_en && !io3) ? per_val : {W{1'bz}};

   always @(posedge clock) begin
      if (carga) per_mem <= Data;
   end

   mestre_barramento #(.Tamanho_Da_Palavra(W), .Ciclos_Espera(CE)) u_dut (
      .clock(clock), .reset(reset), .req(req), .wr(wr), .dado_in(dado_in),
      .Data(Data), .io(io), .carga(carga), .pronto(pronto),
      .dado_out(dado_out), .valido(valido)
   );

   mestre_barramento #(.Tamanho_Da_Palavra(W), .Ciclos_Espera(3)) u_dut3 (
      .clock(clock), .reset(reset), .req(req), .wr(wr), .dado_in(dado_in),
      .Data(Data3), .io(io3), .carga(carga3), .pronto(pronto3),
      .dado_out(dado_out3), .valido(valido3)
   );

   task automatic chk(input string nome, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nome, got, exp);
      end
   endtask

   task automatic chkb(input string nome, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", nome, got, exp);
      end
   endtask

   // Model: each transaction is a list of expected output cycles.
   typedef struct packed {
      logic         io;
      logic         carga;
      logic         pronto;
      logic         valido;
      logic         drive;
      logic         sample;
      logic [W-1:0] data;
   } ciclo_t;

   function automatic ciclo_t mk(input logic io_, input logic carga_, input logic pronto_,
                                 input logic valido_, input logic drive_, input logic sample_,
                                 input logic [W-1:0] d);
      ciclo_t c;
      c.io = io_; c.carga = carga_; c.pronto = pronto_; c.valido = valido_;
      c.drive = drive_; c.sample = sample_; c.data = d;
      return c;
   endfunction

   ciclo_t       fila[$];
   ciclo_t       cur;
   logic [W-1:0] exp_dout = '0;
   logic         model_on = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         fila.delete();
         cur      = mk(1, 0, 1, 0, 0, 0, '0);
         exp_dout = '0;
         model_on = 1'b1;
      end else begin
         if (cur.sample) exp_dout = per_en ? per_val : ZZ;
         if (fila.size() > 0) begin
            cur = fila.pop_front();
         end else if (cur.pronto && req) begin
            if (wr) begin
               cur = mk(1, 0, 0, 0, 1, 0, dado_in);
               fila.push_back(mk(1, 1, 0, 0, 1, 0, dado_in));
               fila.push_back(mk(1, 0, 0, 0, 0, 0, '0));
            end else begin
               cur = mk(0, 0, 0, 0, 0, 0, '0);
               for (int i = 1; i < CE; i++) fila.push_back(mk(0, 0, 0, 0, 0, 0, '0));
               fila.push_back(mk(0, 0, 0, 0, 0, 1, '0));
               fila.push_back(mk(1, 0, 0, 1, 0, 0, '0));
            end
         end else begin
            cur = mk(1, 0, 1, 0, 0, 0, '0);
         end
      end
   end

   always @(negedge clock) begin
      if (model_on) begin
         chkb("io", io, cur.io);
         chkb("carga", carga, cur.carga);
         chkb("pronto", pronto, cur.pronto);
         chkb("valido", valido, cur.valido);
         chk("dado_out", dado_out, exp_dout);
         chk("Data", Data, cur.drive ? cur.data : ((!cur.io && per_en) ? per_val : ZZ));
      end
   end

   task automatic tick;
      @(negedge clock);
      #1;
   endtask

   // One-cycle req pulse, then count output activity over the following cycles.
   task automatic txn(input logic w, input logic [W-1:0] d,
                      output int pl, output int il, output int cl, output int vl,
                      output int pl3, output int il3);
      req = 1'b1; wr = w; dado_in = d;
      tick();
      req = 1'b0;
      pl = 0; il = 0; cl = 0; vl = 0; pl3 = 0; il3 = 0;
      for (int i = 0; i < 12; i++) begin
         if (!pronto)  pl++;
         if (!io)      il++;
         if (carga)    cl++;
         if (valido)   vl++;
         if (!pronto3) pl3++;
         if (!io3)     il3++;
         tick();
      end
   endtask

   initial begin
      int pl, il, cl, vl, pl3, il3;
      bit seen;
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int pl, il, cl, vl, pl3, il3;
      bit seen;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      chkb("reset_pronto", pronto, 1'b1);
      chkb("reset_io", io, 1'b1);
      chk("reset_dout", dado_out, 16'h0000);

      // Plain write
      txn(1'b1, 16'hA5C3, pl, il, cl, vl, pl3, il3);
      chk("wr_pronto_low", 16'(pl), 16'd3);
      chk("wr_io_low", 16'(il), 16'd0);
      chk("wr_carga_cnt", 16'(cl), 16'd1);
      chk("wr_per_mem", per_mem, 16'hA5C3);

      // Plain read on both turnaround settings
      per_en = 1'b1; per_val = 16'h1234;
      txn(1'b0, 16'h0000, pl, il, cl, vl, pl3, il3);
      chk("rd_io_low", 16'(il), 16'd2);
      chk("rd_pronto_low", 16'(pl), 16'd3);
      chk("rd_valido_cnt", 16'(vl), 16'd1);
      chk("rd_dout", dado_out, 16'h1234);
      chk("rd3_io_low", 16'(il3), 16'd4);
      chk("rd3_pronto_low", 16'(pl3), 16'd5);
      chk("rd3_dout", dado_out3, 16'h1234);

      // Write then read back-to-back with req held, plus a stray pulse while busy
      per_val = 16'h5A5A;
      req = 1'b1; wr = 1'b1; dado_in = 16'h00FF;
      tick();
      wr = 1'b0; dado_in = 16'hBEEF;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (pronto) begin
            seen = 1'b1;
            break;
         end
      end
      chkb("b2b_idle_seen", seen, 1'b1);
      tick();
      req = 1'b0;
      tick();
      req = 1'b1;
      tick();
      req = 1'b0;
      vl = 0; cl = 0;
      for (int i = 0; i < 10; i++) begin
         if (valido) vl++;
         if (carga)  cl++;
         tick();
      end
      chk("b2b_valido_cnt", 16'(vl), 16'd1);
      chk("b2b_carga_cnt", 16'(cl), 16'd0);
      chk("b2b_per_mem", per_mem, 16'h00FF);
      chk("b2b_dout", dado_out, 16'h5A5A);
      chkb("b2b_idle_after", pronto, 1'b1);

      // Reset during ESC_DIRIGE with req still high
      req = 1'b1; wr = 1'b1; dado_in = 16'h1357;
      tick();
      reset = 1'b1;
      tick();
      chk("rst_wr_Data", Data, ZZ);
      chkb("rst_wr_io", io, 1'b1);
      chkb("rst_wr_pronto", pronto, 1'b1);
      chkb("rst_wr_carga", carga, 1'b0);
      chk("rst_wr_dout", dado_out, 16'h0000);
      tick();
      reset = 1'b0; req = 1'b0;
      tick(); tick(); tick();
      chk("rst_wr_per_mem", per_mem, 16'h00FF);

      // Reset during the read turnaround
      per_val = 16'h2468;
      req = 1'b1; wr = 1'b0;
      tick();
      reset = 1'b1; req = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chkb("rst_rd_io", io, 1'b1);
      chk("rst_rd_dout", dado_out, 16'h0000);
      for (int i = 0; i < 6; i++) tick();

      // Read with nobody driving the bus
      per_en = 1'b0;
      txn(1'b0, 16'h0000, pl, il, cl, vl, pl3, il3);
      chk("undrv_valido_cnt", 16'(vl), 16'd1);
      chk("undrv_io_low", 16'(il), 16'd2);
      chk("undrv_dout", dado_out, ZZ);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
